// File: rtl/icache_responder_if.sv
// Fetch-side (iaddr/idata/ihit) and refill-side (req/ack memory bus) signals of icache_responder.
// The slave modport is the cache's view; the master modport is the fetch stage / memory side.
interface icache_responder_if;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic        ihit;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  iaddr, mem_ack, mem_rdata,
      output idata, ihit, mem_req, mem_addr
   );

   modport master (
      output iaddr, mem_ack, mem_rdata,
      input  idata, ihit, mem_req, mem_addr
   );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache with combinational hit lookup and a line refill FSM.
// Optional ICACHE_FLUSH_EN adds a flush input that invalidates every line.
module icache_responder #(
   parameter int unsigned LINES          = 16,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input logic clk,
   input logic rst,
`ifdef ICACHE_FLUSH_EN
   input logic flush,
`endif
   icache_responder_if.slave bus_io
);

   localparam int unsigned Off  = $clog2(WORDS_PER_LINE);
   localparam int unsigned Idx  = $clog2(LINES);
   localparam int unsigned TagW = 30 - Off - Idx;

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StRefill = 1'b1;

   localparam logic [Off-1:0] LastWord = Off'(WORDS_PER_LINE - 1);

   logic [Off-1:0]  off;
   logic [Idx-1:0]  idx;
   logic [TagW-1:0] tag;
   logic            lookup_hit;
   logic            flush_req;
   logic            fill_we;
   logic            fill_done;
   logic            unused_iaddr;

   logic [0:0]      state_q, state_d;
   logic [Off-1:0]  cnt_q, cnt_d;
   logic [LINES-1:0] valid_q, valid_d;
   logic [TagW-1:0] miss_tag_q, miss_tag_d;
   logic [Idx-1:0]  miss_idx_q, miss_idx_d;
   logic            mem_req_q, mem_req_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic            flush_pend_q, flush_pend_d;

   logic [TagW-1:0] tag_q  [LINES];
   logic [31:0]     data_q [LINES][WORDS_PER_LINE];

`ifdef ICACHE_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign off          = bus_io.iaddr[2 +: Off];
   assign idx          = bus_io.iaddr[2 + Off +: Idx];
   assign tag          = bus_io.iaddr[31 -: TagW];
   assign unused_iaddr = ^bus_io.iaddr[1:0];

   assign lookup_hit = (state_q == StIdle) && valid_q[idx] && (tag_q[idx] == tag);

   assign bus_io.ihit     = ~rst & lookup_hit & ~flush_req;
   assign bus_io.idata    = bus_io.ihit ? data_q[idx][off] : '0;
   assign bus_io.mem_req  = mem_req_q;
   assign bus_io.mem_addr = mem_addr_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      miss_tag_d   = miss_tag_q;
      miss_idx_d   = miss_idx_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      flush_pend_d = flush_pend_q;
      fill_we      = 1'b0;
      fill_done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (flush_req) begin
               valid_d = '0;
            end else if (!lookup_hit) begin
               miss_tag_d   = tag;
               miss_idx_d   = idx;
               cnt_d        = '0;
               mem_req_d    = 1'b1;
               mem_addr_d   = {bus_io.iaddr[31:2+Off], {Off{1'b0}}, 2'b00};
               valid_d[idx] = 1'b0;
               state_d      = StRefill;
            end
         end
         StRefill: begin
            flush_pend_d = flush_pend_q | flush_req;
            if (bus_io.mem_ack) begin
               fill_we = 1'b1;
               if (cnt_q == LastWord) begin
                  fill_done           = 1'b1;
                  mem_req_d           = 1'b0;
                  valid_d[miss_idx_q] = 1'b1;
                  // A flush seen during the refill also discards the line just fetched.
                  if (flush_pend_q || flush_req) begin
                     valid_d = '0;
                  end
                  flush_pend_d = 1'b0;
                  state_d      = StIdle;
               end else begin
                  cnt_d      = cnt_q + 1'b1;
                  mem_addr_d = mem_addr_q + 32'd4;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         valid_q      <= '0;
         miss_tag_q   <= '0;
         miss_idx_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         miss_tag_q   <= miss_tag_d;
         miss_idx_q   <= miss_idx_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // Tag and data arrays need no reset; valid_q gates every use.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_q[miss_idx_q][cnt_q] <= bus_io.mem_rdata;
      end
      if (fill_done) begin
         tag_q[miss_idx_q] <= miss_tag_q;
      end
   end

endmodule
